// File: rtl/interp_pass_sequencer_pkg.sv
// Shared constants and types for the interpolation pass sequencer.
package interp_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned HEIGHT   = 16;
  localparam int unsigned LEAD     = 7;
  localparam int unsigned TAIL     = 6;
  localparam int unsigned CAP_LAT  = 13;
  localparam int unsigned PW       = 8;
  localparam int unsigned AW       = $clog2(WIDTH * HEIGHT);
  localparam int unsigned LINE_MAX = (WIDTH > HEIGHT) ? WIDTH : HEIGHT;
  localparam int unsigned KW       = $clog2(CAP_LAT + LINE_MAX);
  localparam int unsigned IW       = $clog2(LINE_MAX);

  typedef enum logic {DIR_H, DIR_V} pass_dir_t;

  typedef enum logic [2:0] {
    BUF_PIX, BUF_A, BUF_B, BUF_C, BUF_DHN, BUF_EIP, BUF_FJQ, BUF_GKR
  } buf_sel_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

endpackage

// File: rtl/interp_pass_sequencer_if.sv
// Scheduler / buffer / filter side signals of the pass sequencer.
interface interp_pass_sequencer_if;
  import interp_pkg::*;

  logic           start;
  pass_dir_t      dir;
  buf_sel_t       src_sel;
  buf_sel_t       dst_sel;
  logic           stall;
  logic [PW-1:0]  rd_data;
  logic           busy;
  logic           done;
  logic [AW-1:0]  rd_addr;
  logic [PW-1:0]  pix_out;
  logic           shift_en;
  logic           cap_valid;
  logic [AW-1:0]  cap_addr;
  buf_sel_t       src_sel_q;
  buf_sel_t       dst_sel_q;

  modport master (
    output start, dir, src_sel, dst_sel, stall, rd_data,
    input  busy, done, rd_addr, pix_out, shift_en, cap_valid, cap_addr,
           src_sel_q, dst_sel_q
  );

  modport slave (
    input  start, dir, src_sel, dst_sel, stall, rd_data,
    output busy, done, rd_addr, pix_out, shift_en, cap_valid, cap_addr,
           src_sel_q, dst_sel_q
  );

endinterface

// File: rtl/interp_pass_sequencer_addr_gen.sv
// Maps line cycle k and line index i to the padded read address and the capture address.
module interp_addr_gen import interp_pkg::*; (
  input  logic [KW-1:0] k_i,
  input  logic [IW-1:0] i_i,
  input  pass_dir_t     dir_i,
  output logic [AW-1:0] rd_addr_o,
  output logic [AW-1:0] cap_addr_o
);

  int len;
  int p;
  int q;

  always_comb begin
    len = (dir_i == DIR_V) ? int'(HEIGHT) : int'(WIDTH);
    // Signed clamp replicates the first/last pixel during the pad phases
    p = int'(k_i) - int'(LEAD);
    if (p < 0)            p = 0;
    else if (p > len - 1) p = len - 1;
    q = int'(k_i) - int'(CAP_LAT);
    if (q < 0) q = 0;
    if (dir_i == DIR_V) begin
      rd_addr_o  = AW'(p * int'(WIDTH) + int'(i_i));
      cap_addr_o = AW'(q * int'(WIDTH) + int'(i_i));
    end else begin
      rd_addr_o  = AW'(int'(i_i) * int'(WIDTH) + p);
      cap_addr_o = AW'(int'(i_i) * int'(WIDTH) + q);
    end
  end

endmodule

// File: rtl/interp_pass_sequencer.sv
// Walks every row or column of the image, feeding one padded pixel per cycle to the
// 8-tap filter and generating the write strobe/address for its outputs.
module interp_pass_sequencer import interp_pkg::*; (
  input  logic                    clock,
  input  logic                    reset,
  interp_pass_sequencer_if.slave  bus
);

  seq_state_t     state_q, state_d;
  logic [KW-1:0]  k_q, k_d, k_last;
  logic [IW-1:0]  i_q, i_d, i_last;
  pass_dir_t      dir_q, dir_d;
  buf_sel_t       src_sel_q, src_sel_d;
  buf_sel_t       dst_sel_q, dst_sel_d;
  logic [PW-1:0]  pix_q, pix_d;
  logic           shift_q, shift_d;
  logic           run;
  logic           cap_valid;
  logic [AW-1:0]  rd_raw;
  logic [AW-1:0]  cap_raw;

  interp_addr_gen u_addr_gen (
    .k_i        (k_q),
    .i_i        (i_q),
    .dir_i      (dir_q),
    .rd_addr_o  (rd_raw),
    .cap_addr_o (cap_raw)
  );

  assign k_last = (dir_q == DIR_V) ? KW'(CAP_LAT + HEIGHT - 1) : KW'(CAP_LAT + WIDTH - 1);
  assign i_last = (dir_q == DIR_V) ? IW'(WIDTH - 1) : IW'(HEIGHT - 1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      k_q       <= '0;
      i_q       <= '0;
      dir_q     <= DIR_H;
      src_sel_q <= BUF_PIX;
      dst_sel_q <= BUF_PIX;
      pix_q     <= '0;
      shift_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      i_q       <= i_d;
      dir_q     <= dir_d;
      src_sel_q <= src_sel_d;
      dst_sel_q <= dst_sel_d;
      pix_q     <= pix_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    i_d       = i_q;
    dir_d     = dir_q;
    src_sel_d = src_sel_q;
    dst_sel_d = dst_sel_q;
    pix_d     = pix_q;
    shift_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          k_d       = '0;
          i_d       = '0;
          dir_d     = bus.dir;
          src_sel_d = bus.src_sel;
          dst_sel_d = bus.dst_sel;
        end
      end
      RUN: begin
        if (!bus.stall) begin
          shift_d = 1'b1;
          pix_d   = bus.rd_data;
          if (k_q == k_last) begin
            k_d = '0;
            if (i_q == i_last) begin
              i_d     = '0;
              state_d = DONE;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Filter output for line position q is ready CAP_LAT cycles into the line
  assign run       = (state_q == RUN);
  assign cap_valid = run && !bus.stall && (k_q >= KW'(CAP_LAT));

  assign bus.busy      = run;
  assign bus.done      = (state_q == DONE);
  assign bus.rd_addr   = run ? rd_raw : '0;
  assign bus.cap_valid = cap_valid;
  assign bus.cap_addr  = cap_valid ? cap_raw : '0;
  assign bus.pix_out   = pix_q;
  assign bus.shift_en  = shift_q;
  assign bus.src_sel_q = src_sel_q;
  assign bus.dst_sel_q = dst_sel_q;

endmodule

// File: tb/tb_interp_pass_sequencer.sv
// Directed bench for interp_pass_sequencer over a ramp source image (value = address).
module tb_interp_pass_sequencer;
  import interp_pkg::*;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;
  int   cyc;
  int   prev;
  int   e;

  logic [PW-1:0] src_mem [2**AW];

  interp_pass_sequencer_if bus ();

  interp_pass_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always_comb bus.rd_data = src_mem[bus.rd_addr];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic advance(input int n);
    for (int s = 0; s < n; s++) step();
  endtask

  task automatic wait_done();
    for (int n = 0; n < 1000 && !bus.done; n++) step();
    chk("done_seen", 32'(bus.done), 32'd1);
  endtask

  task automatic start_pass(input pass_dir_t d, input buf_sel_t s, input buf_sel_t t);
    bus.dir     = d;
    bus.src_sel = s;
    bus.dst_sel = t;
    bus.start   = 1'b1;
    cyc = 0;
    step();
    bus.start = 1'b0;
  endtask

  // Padded position within a line of 16 pixels
  function automatic int pk(input int k);
    if (k < 7)  return 0;
    if (k < 23) return k - 7;
    return 15;
  endfunction

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    cyc    = 0;
    prev   = 0;
    e      = 0;
    for (int a = 0; a < 2**AW; a++) src_mem[a] = PW'(a);
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.dir     = DIR_H;
    bus.src_sel = BUF_PIX;
    bus.dst_sel = BUF_PIX;
    bus.stall   = 1'b0;

    #12;
    chk("rst_busy",  32'(bus.busy), 0);
    chk("rst_done",  32'(bus.done), 0);
    chk("rst_rd",    32'(bus.rd_addr), 0);
    chk("rst_pix",   32'(bus.pix_out), 0);
    chk("rst_shift", 32'(bus.shift_en), 0);
    chk("rst_capv",  32'(bus.cap_valid), 0);
    chk("rst_capa",  32'(bus.cap_addr), 0);
    chk("rst_src",   32'(bus.src_sel_q), 0);
    reset = 1'b0;
    step();
    chk("idle_busy", 32'(bus.busy), 0);

    // Horizontal pass, line 0 in detail
    start_pass(DIR_H, BUF_PIX, BUF_A);
    chk("h_busy", 32'(bus.busy), 1);
    chk("h_dst",  32'(bus.dst_sel_q), 32'(BUF_A));
    for (int k = 0; k < 29; k++) begin
      e = pk(k);
      chk("h_rd", 32'(bus.rd_addr), 32'(e));
      if (k == 0) chk("h_shift0", 32'(bus.shift_en), 0);
      else begin
        chk("h_shift", 32'(bus.shift_en), 1);
        chk("h_pix", 32'(bus.pix_out), 32'(prev));
      end
      chk("h_capv", 32'(bus.cap_valid), 32'(k >= 13));
      chk("h_capa", 32'(bus.cap_addr), (k >= 13) ? 32'(k - 13) : 0);
      prev = e;
      step();
    end
    wait_done();
    chk("h_done_cyc", 32'(cyc), 465);
    chk("h_busy_done", 32'(bus.busy), 0);
    step();
    chk("h_done_pulse", 32'(bus.done), 0);
    chk("h_idle_rd", 32'(bus.rd_addr), 0);

    // Vertical pass, line 3 in detail
    start_pass(DIR_V, BUF_B, BUF_EIP);
    chk("v_src", 32'(bus.src_sel_q), 32'(BUF_B));
    chk("v_dst", 32'(bus.dst_sel_q), 32'(BUF_EIP));
    advance(87);
    prev = 242;
    for (int k = 0; k < 29; k++) begin
      e = pk(k) * 16 + 3;
      chk("v_rd", 32'(bus.rd_addr), 32'(e));
      chk("v_pix", 32'(bus.pix_out), 32'(prev));
      chk("v_capv", 32'(bus.cap_valid), 32'(k >= 13));
      chk("v_capa", 32'(bus.cap_addr), (k >= 13) ? 32'((k - 13) * 16 + 3) : 0);
      prev = e;
      step();
    end
    wait_done();
    chk("v_done_cyc", 32'(cyc), 465);
    step();

    // Five-cycle stall at line 2, k=10
    start_pass(DIR_H, BUF_C, BUF_FJQ);
    advance(68);
    chk("s_rd_pre", 32'(bus.rd_addr), 35);
    bus.stall = 1'b1;
    #1;
    for (int s = 0; s < 5; s++) begin
      chk("s_rd", 32'(bus.rd_addr), 35);
      chk("s_shift", 32'(bus.shift_en), 32'(s == 0));
      chk("s_pix", 32'(bus.pix_out), 34);
      chk("s_capv", 32'(bus.cap_valid), 0);
      step();
    end
    bus.stall = 1'b0;
    chk("s_rd_rel", 32'(bus.rd_addr), 35);
    chk("s_shift_rel", 32'(bus.shift_en), 0);
    chk("s_pix_rel", 32'(bus.pix_out), 34);
    step();
    chk("s_rd_next", 32'(bus.rd_addr), 36);
    chk("s_shift_next", 32'(bus.shift_en), 1);
    chk("s_pix_next", 32'(bus.pix_out), 35);
    wait_done();
    chk("s_done_cyc", 32'(cyc), 470);
    step();

    // Start pulse during RUN is ignored
    start_pass(DIR_H, BUF_A, BUF_DHN);
    advance(99);
    bus.dir     = DIR_V;
    bus.src_sel = BUF_GKR;
    bus.dst_sel = BUF_B;
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ig_src", 32'(bus.src_sel_q), 32'(BUF_A));
    chk("ig_dst", 32'(bus.dst_sel_q), 32'(BUF_DHN));
    chk("ig_rd", 32'(bus.rd_addr), 54);
    chk("ig_capa", 32'(bus.cap_addr), 48);
    wait_done();
    chk("ig_done_cyc", 32'(cyc), 465);

    // Start in DONE ignored, start in the following IDLE cycle accepted
    bus.dir     = DIR_H;
    bus.src_sel = BUF_C;
    bus.dst_sel = BUF_GKR;
    bus.start   = 1'b1;
    step();
    chk("bb_busy_idle", 32'(bus.busy), 0);
    chk("bb_done_idle", 32'(bus.done), 0);
    step();
    bus.start = 1'b0;
    chk("bb_busy_run", 32'(bus.busy), 1);
    chk("bb_rd", 32'(bus.rd_addr), 0);
    chk("bb_src", 32'(bus.src_sel_q), 32'(BUF_C));

    // Mid-pass abort at line 7, k=20
    advance(223);
    chk("r_rd", 32'(bus.rd_addr), 125);
    chk("r_capv", 32'(bus.cap_valid), 1);
    chk("r_capa", 32'(bus.cap_addr), 119);
    bus.stall = 1'b1;
    #1;
    chk("r_stall_capv", 32'(bus.cap_valid), 0);
    chk("r_stall_capa", 32'(bus.cap_addr), 0);
    chk("r_stall_rd", 32'(bus.rd_addr), 125);
    #1;
    reset = 1'b1;
    #1;
    bus.stall = 1'b0;
    chk("ra_busy",  32'(bus.busy), 0);
    chk("ra_done",  32'(bus.done), 0);
    chk("ra_rd",    32'(bus.rd_addr), 0);
    chk("ra_pix",   32'(bus.pix_out), 0);
    chk("ra_shift", 32'(bus.shift_en), 0);
    chk("ra_capv",  32'(bus.cap_valid), 0);
    chk("ra_src",   32'(bus.src_sel_q), 0);
    chk("ra_dst",   32'(bus.dst_sel_q), 0);
    step();
    chk("ra_done_hold", 32'(bus.done), 0);
    reset = 1'b0;
    step();
    chk("ra_idle", 32'(bus.busy), 0);
    chk("ra_idle_done", 32'(bus.done), 0);

    start_pass(DIR_H, BUF_PIX, BUF_GKR);
    chk("rs_busy", 32'(bus.busy), 1);
    chk("rs_rd0", 32'(bus.rd_addr), 0);
    advance(8);
    chk("rs_rd8", 32'(bus.rd_addr), 1);
    wait_done();
    chk("rs_done_cyc", 32'(cyc), 465);
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/interp_pass_sequencer.md
Name: interp_pass_sequencer

Overview:
Controller that drives one separable 8-tap half/quarter-pel filter through a full image pass. It walks lines, horizontal (rows) or vertical (columns), of a WIDTH x HEIGHT pixel buffer. Each line is edge-padded by replicating its first and last pixels. The block streams one pixel per cycle into the filter's shift buffer and generates the write strobe and address for the filter's a/b/c outputs. It replaces hand-written bench loops. A top-level scheduler issues the five passes (ABC, DHN, EIP, FJQ, GKR) through start/done.

Parameters:
WIDTH, 16, pixels per row
HEIGHT, 16, pixels per column
LEAD, 7, leading replications of first pixel per line
TAIL, 6, trailing replications of last pixel per line
CAP_LAT, 13, line cycle index of first valid filter output; must equal LEAD+TAIL
AW, $clog2(WIDTH*HEIGHT) = 8, buffer address width

Ports:
clock  in  1  system clock, all state on posedge
reset  in  1  asynchronous, active-high reset
start  in  1  pulse; begin a pass (accepted in IDLE only)
dir  in  1  0 = horizontal (rows), 1 = vertical (columns); latched at start
src_sel  in  3  source buffer id (buf_sel_t); latched at start
dst_sel  in  3  destination group id (buf_sel_t); latched at start
stall  in  1  downstream back-pressure; freezes sequencing
rd_data  in  8  source pixel at rd_addr (combinational read)
busy  out  1  high in RUN
done  out  1  one-cycle pulse on pass completion
rd_addr  out  AW  source read address
pix_out  out  8  registered pixel to filter data_in
shift_en  out  1  registered; filter shifts its buffer when high
cap_valid  out  1  filter a/b/c outputs are valid for cap_addr this cycle
cap_addr  out  AW  destination address for a/b/c outputs
src_sel_q, dst_sel_q  out  3  latched selects, steer buffer muxes

Behaviour:
- Reset (async, immediate): state=IDLE, k=0, i=0. All outputs 0.
- Clock and reset are decided as one clock, named clock, with an asynchronous active-high reset named reset.
- LEN = dir ? HEIGHT : WIDTH. NLINES = dir ? WIDTH : HEIGHT. Line cycles = CAP_LAT+LEN (29 by default).
- FSM: IDLE -> RUN on start, with k=0, i=0, and selects latched. RUN -> DONE on the final non-stalled cycle of the last line. DONE -> IDLE unconditionally. done=1 only in DONE.
- A start in RUN or DONE is ignored.
- RUN, non-stalled cycle: k increments. When k=LEN+CAP_LAT-1, k wraps to 0 and i increments.
- Stalled cycle: k, i, pix_out and rd_addr are held. shift_en=0 next cycle and cap_valid=0 this cycle.
- Position: p = clamp(k-LEAD, 0, LEN-1), signed compare with no underflow.
- Horizontal read address: rd_addr = i*WIDTH + p.
- Vertical read address: rd_addr = p*WIDTH + i.
- rd_addr = 0 outside RUN.
- Feed: pix_out <= rd_data and shift_en <= 1 on each non-stalled RUN cycle. Otherwise shift_en <= 0 and pix_out is held.
- Capture: cap_valid = RUN & !stall & (k >= CAP_LAT). q = k-CAP_LAT.
- Horizontal capture address: cap_addr = i*WIDTH + q.
- Vertical capture address: cap_addr = q*WIDTH + i.
- Outside capture cycles, cap_addr = 0.
- Pad-phase pixels keep the filter buffer primed across line boundaries; no flush cycles are needed.
- Address arithmetic is unsigned AW bits, with no wrap inside a legal pass.
- Reset mid-pass aborts immediately with no done pulse. The destination may be partially written.

Decomposition:
- Package interp_pkg holds:
  - constants WIDTH, HEIGHT, LEAD, TAIL, CAP_LAT;
  - typedef enum pass_dir_t {DIR_H, DIR_V};
  - typedef enum logic [2:0] buf_sel_t {BUF_PIX, BUF_A, BUF_B, BUF_C, BUF_DHN, BUF_EIP, BUF_FJQ, BUF_GKR};
  - typedef enum seq_state_t {IDLE, RUN, DONE}.
- One sub-module: interp_addr_gen, combinational. It produces rd_addr and cap_addr from (k, i, dir) and is instantiated once.

Test Plan:
- Horizontal pass, src = ramp (value = addr), no stall.
  - Line 0: rd_addr = 0 x7, 0..15, 15 x6.
  - cap_valid first high at k=13, with cap_addr 0..15.
  - done pulses exactly 465 cycles after start (464 RUN cycles + 1).
- Vertical pass, line i=3.
  - rd_addr = 3 x7, 3,19,...,243, 243 x6.
  - cap_addr sequence 3,19,...,243.
  - pix_out lags rd_data by one cycle.
- Stall 5 cycles at line 2, k=10.
  - rd_addr, pix_out, k and i are held.
  - shift_en=0 and cap_valid=0 during the stall.
  - done is delayed by exactly 5 cycles vs the no-stall run.
- start pulse at RUN cycle 100 with different dir/src_sel.
  - Ignored: latched selects unchanged, pass completes normally.
- reset asserted asynchronously mid-pass (line 7).
  - All outputs 0 immediately, with no done pulse.
  - A subsequent start runs a full pass from i=0.
- Back-to-back: start asserted in the DONE cycle is ignored. Start one cycle later (IDLE) is accepted, with busy=1 the next cycle.
